// File: rtl/mfrc522_spi_master_if.sv
`default_nettype none
// ============================================================================
// Module      : mfrc522_spi_master_if
// Description : Request/response and SPI pin bundle for mfrc522_spi_master.
//               "master" is the controller's view, "slave" the user/pin side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mfrc522_spi_master_if #(
    parameter int LEN_W = 6
);
    logic             start;
    logic             rw;
    logic [5:0]       addr;
    logic [LEN_W-1:0] len;
    logic [7:0]       wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             busy;
    logic             done;
    logic             err;
    logic             spi_sclk;
    logic             spi_cs_n;
    logic             spi_mosi;
    logic             spi_miso;

    modport master (
        input  start, rw, addr, len, wr_data, wr_valid, spi_miso,
        output wr_ready, rd_data, rd_valid, busy, done, err,
               spi_sclk, spi_cs_n, spi_mosi
    );

    modport slave (
        output start, rw, addr, len, wr_data, wr_valid, spi_miso,
        input  wr_ready, rd_data, rd_valid, busy, done, err,
               spi_sclk, spi_cs_n, spi_mosi
    );
endinterface
`default_nettype wire

// File: rtl/mfrc522_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : mfrc522_spi_master
// Description : SPI mode-0 master for MFRC522 register read/write bursts.
//               Sends {rw, addr, 0} followed by data/dummy bytes, streams
//               write bytes in through a ready/valid handshake and returns
//               read bytes as single-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module mfrc522_spi_master #(
    parameter int CLK_DIV  = 25,
    parameter int CS_SETUP = 100,
    parameter int CS_HOLD  = 25,
    parameter int LEN_W    = 6
) (
    input wire                    clk_25mhz,
    input wire                    rst_n,
    mfrc522_spi_master_if.master  bus
);

    // One counter serves the setup, half-period and hold intervals.
    localparam int c_cnt_max = (CLK_DIV > CS_SETUP) ?
                               ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD) :
                               ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    // SETUP is shortened by the LOAD cycle and the first low half-period so
    // the first rising edge lands exactly CS_SETUP cycles after CS falls.
    localparam int c_setup_i = (CS_SETUP >= CLK_DIV + 2) ? (CS_SETUP - CLK_DIV - 2) : 0;

    localparam logic [c_cnt_w-1:0] c_div_last   = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_setup_last = c_cnt_w'(c_setup_i);
    localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(CS_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [LEN_W:0]     c_byte_one   = (LEN_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t             r_state,   w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt,     w_cnt_nxt;
    logic [2:0]         r_bit,     w_bit_nxt;
    // One bit wider than len so the wire-byte index reaches len without wrap.
    logic [LEN_W:0]     r_byte,    w_byte_nxt;
    logic               r_rw,      w_rw_nxt;
    logic [5:0]         r_addr,    w_addr_nxt;
    logic [LEN_W-1:0]   r_len,     w_len_nxt;
    logic [7:0]         r_tx,      w_tx_nxt;
    logic [7:0]         r_rx,      w_rx_nxt;
    logic               r_hi,      w_hi_nxt;
    logic               r_sclk,    w_sclk_nxt;
    logic               r_cs_n,    w_cs_n_nxt;
    logic               r_busy,    w_busy_nxt;
    logic               r_done,    w_done_nxt;
    logic               r_err,     w_err_nxt;
    logic [7:0]         r_rd_data, w_rd_data_nxt;
    logic               r_rd_valid, w_rd_valid_nxt;
    logic               w_wr_ready;

    logic [7:0]         w_addr_byte;
    logic               w_first_byte;
    logic               w_last_byte;
    logic               w_need_data;
    logic [7:0]         w_load_byte;

    assign w_addr_byte  = {r_rw, r_addr, 1'b0};
    assign w_first_byte = (r_byte == '0);
    assign w_last_byte  = (r_byte == {1'b0, r_len});
    // Only write data bytes wait on the user; address/dummy bytes never stall.
    assign w_need_data  = !r_rw && !w_first_byte;
    assign w_load_byte  = r_rw ? (w_last_byte ? 8'h00 : w_addr_byte)
                               : (w_first_byte ? w_addr_byte : bus.wr_data);

    // State and all output registers; reset forces the idle pin levels.
    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_byte     <= '0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_hi       <= 1'b0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_byte     <= w_byte_nxt;
            r_rw       <= w_rw_nxt;
            r_addr     <= w_addr_nxt;
            r_len      <= w_len_nxt;
            r_tx       <= w_tx_nxt;
            r_rx       <= w_rx_nxt;
            r_hi       <= w_hi_nxt;
            r_sclk     <= w_sclk_nxt;
            r_cs_n     <= w_cs_n_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
        end
    end

    // Next-state and next-output-register logic for the transaction sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_bit_nxt      = r_bit;
        w_byte_nxt     = r_byte;
        w_rw_nxt       = r_rw;
        w_addr_nxt     = r_addr;
        w_len_nxt      = r_len;
        w_tx_nxt       = r_tx;
        w_rx_nxt       = r_rx;
        w_hi_nxt       = r_hi;
        w_sclk_nxt     = r_sclk;
        w_cs_n_nxt     = r_cs_n;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_rd_data_nxt  = r_rd_data;
        w_rd_valid_nxt = 1'b0;
        w_wr_ready     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        w_rw_nxt    = bus.rw;
                        w_addr_nxt  = bus.addr;
                        w_len_nxt   = bus.len;
                        w_byte_nxt  = '0;
                        w_cnt_nxt   = '0;
                        w_cs_n_nxt  = 1'b0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_SETUP;
                    end else begin
                        // Empty request: reject without touching the bus.
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_SETUP: begin
                if (r_cnt == c_setup_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end

            S_LOAD: begin
                if (!w_need_data || bus.wr_valid) begin
                    w_wr_ready  = w_need_data;
                    w_tx_nxt    = w_load_byte;
                    w_bit_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_hi_nxt    = 1'b0;
                    w_state_nxt = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (!r_hi) begin
                    // Low half: MOSI already stable, rise and sample MISO.
                    if (r_cnt == c_div_last) begin
                        w_sclk_nxt = 1'b1;
                        w_rx_nxt   = {r_rx[6:0], bus.spi_miso};
                        w_hi_nxt   = 1'b1;
                        w_cnt_nxt  = '0;
                    end else begin
                        w_cnt_nxt  = r_cnt + c_cnt_one;
                    end
                end else begin
                    // Byte 0 of a read is the address echo and is dropped.
                    if (r_cnt == '0 && r_bit == 3'd7 && r_rw && !w_first_byte) begin
                        w_rd_data_nxt  = r_rx;
                        w_rd_valid_nxt = 1'b1;
                    end
                    if (r_cnt == c_div_last) begin
                        w_sclk_nxt = 1'b0;
                        w_cnt_nxt  = '0;
                        if (r_bit == 3'd7) begin
                            if (w_last_byte) begin
                                w_tx_nxt    = '0;
                                w_state_nxt = S_HOLD;
                            end else begin
                                w_byte_nxt  = r_byte + c_byte_one;
                                w_state_nxt = S_LOAD;
                            end
                        end else begin
                            w_bit_nxt = r_bit + 3'd1;
                            w_tx_nxt  = {r_tx[6:0], 1'b0};
                            w_hi_nxt  = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
            end

            S_HOLD: begin
                if (r_cnt == c_hold_last) begin
                    w_cs_n_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end

            S_GAP: begin
                if (r_cnt == c_hold_last) begin
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end

            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.spi_sclk = r_sclk;
    assign bus.spi_cs_n = r_cs_n;
    assign bus.spi_mosi = r_tx[7];
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.wr_ready = w_wr_ready;

endmodule
`default_nettype wire

// File: tb/tb_mfrc522_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mfrc522_spi_master
// Description : Directed self-checking bench for mfrc522_spi_master with a
//               mode-0 MFRC522 slave model on the SPI pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mfrc522_spi_master;

    logic clk;
    logic rst_n;

    mfrc522_spi_master_if #(.LEN_W(6)) bus ();

    mfrc522_spi_master #(
        .CLK_DIV  (25),
        .CS_SETUP (100),
        .CS_HOLD  (25),
        .LEN_W    (6)
    ) dut (
        .clk_25mhz (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave model response bytes, indexed by wire byte.
    logic [7:0] resp [8];
    // Write data bytes offered on wr_data.
    logic [7:0] wr_arr [4];

    // Monitor state (written only by the monitor process).
    int         mon_cyc      = 0;
    int         mon_cs_falls = 0;
    int         mon_nrise    = 0;
    int         mon_nfall    = 0;
    int         mon_nbytes   = 0;
    int         mon_t_cs_fall, mon_t_rise1, mon_t_rise2, mon_t_fall1;
    int         mon_t_last_fall, mon_t_cs_rise, mon_t_done;
    logic [7:0] mon_mosi [16];
    logic [7:0] mon_sh;
    logic [7:0] mon_rb;
    logic       mon_prev_sclk = 1'b0;
    logic       mon_prev_cs   = 1'b1;

    // Results of the last run_txn call.
    int         n_wrr, n_rdv, n_done, stall_cyc, stall_bad;
    logic       t_finished, t_err;
    logic [7:0] rd_log [8];

    // MFRC522 pin model: logs MOSI on rising edges, drives MISO on falling.
    always @(negedge clk) begin
        if (mon_cyc == 0) bus.spi_miso = 1'b0;
        mon_cyc++;
        if (mon_prev_cs && !bus.spi_cs_n) begin
            mon_cs_falls++;
            mon_t_cs_fall = mon_cyc;
            mon_nrise  = 0;
            mon_nfall  = 0;
            mon_nbytes = 0;
            mon_sh     = 8'h00;
            mon_rb     = resp[0];
            bus.spi_miso = mon_rb[7];
        end
        if (!mon_prev_cs && bus.spi_cs_n) mon_t_cs_rise = mon_cyc;
        if (bus.done) mon_t_done = mon_cyc;
        if (!bus.spi_cs_n) begin
            if (!mon_prev_sclk && bus.spi_sclk) begin
                if (mon_nrise == 0) mon_t_rise1 = mon_cyc;
                if (mon_nrise == 1) mon_t_rise2 = mon_cyc;
                mon_sh = {mon_sh[6:0], bus.spi_mosi};
                mon_nrise++;
                if (mon_nrise % 8 == 0 && mon_nbytes < 16) begin
                    mon_mosi[4'(mon_nbytes)] = mon_sh;
                    mon_nbytes++;
                end
            end
            if (mon_prev_sclk && !bus.spi_sclk) begin
                if (mon_nfall == 0) mon_t_fall1 = mon_cyc;
                mon_nfall++;
                mon_t_last_fall = mon_cyc;
                if (mon_nrise / 8 < 8) begin
                    mon_rb = resp[3'(mon_nrise / 8)];
                    bus.spi_miso = mon_rb[3'(7 - mon_nrise % 8)];
                end
            end
        end
        mon_prev_sclk = bus.spi_sclk;
        mon_prev_cs   = bus.spi_cs_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and service it until done (bounded). stall_after is
    // the write-data index whose wr_valid is withheld 500 cycles (-1: none);
    // poke_cyc is the loop cycle at which a stray start is pulsed (-1: none).
    task automatic run_txn(input logic rw, input logic [5:0] addr, input logic [5:0] len,
                           input int stall_after, input int poke_cyc);
        int  wr_idx;
        int  hold;
        logic take;
        n_wrr = 0; n_rdv = 0; n_done = 0; stall_cyc = 0; stall_bad = 0;
        t_finished = 1'b0; t_err = 1'b0;
        wr_idx = 0; hold = 0; take = 1'b0;
        bus.rw = rw; bus.addr = addr; bus.len = len; bus.start = 1'b1;
        bus.wr_data  = wr_arr[0];
        bus.wr_valid = !rw;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 20000 && !t_finished; c++) begin
            if (take) begin
                take = 1'b0;
                wr_idx++;
                bus.wr_data = wr_arr[2'(wr_idx)];
                if (wr_idx >= int'(len)) bus.wr_valid = 1'b0;
                else if (wr_idx == stall_after) begin
                    bus.wr_valid = 1'b0;
                    hold = 500;
                end
            end
            if (hold > 0) begin
                hold--;
                if (mon_nfall >= 8 * (stall_after + 1)) begin
                    stall_cyc++;
                    if (bus.spi_sclk !== 1'b0 || bus.spi_cs_n !== 1'b0) stall_bad++;
                end
                if (hold == 0) bus.wr_valid = 1'b1;
            end
            if (c == poke_cyc) begin
                bus.start = 1'b1; bus.rw = ~rw; bus.addr = 6'h3F; bus.len = 6'd5;
            end else if (c == poke_cyc + 1) begin
                bus.start = 1'b0;
            end
            #1;
            if (bus.wr_ready === 1'b1) begin n_wrr++; take = 1'b1; end
            if (bus.rd_valid === 1'b1 && n_rdv < 8) begin
                rd_log[3'(n_rdv)] = bus.rd_data;
                n_rdv++;
            end
            if (bus.done === 1'b1) begin
                n_done++;
                t_err = bus.err;
                t_finished = 1'b1;
            end
            tick();
        end
        check("txn_finished", 32'(t_finished), 32'd1);
    endtask

    int cf0;
    int extra_done;
    logic found;

    initial begin
        bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.len = '0;
        bus.wr_data = '0; bus.wr_valid = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) resp[i] = 8'h00;
        for (int i = 0; i < 4; i++) wr_arr[i] = 8'h00;
        repeat (3) tick();

        // Reset state
        check("rst_cs_n",     32'(bus.spi_cs_n), 32'd1);
        check("rst_sclk",     32'(bus.spi_sclk), 32'd0);
        check("rst_mosi",     32'(bus.spi_mosi), 32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_err",      32'(bus.err),      32'd0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data",  32'(bus.rd_data),  32'h00);
        rst_n = 1'b1;
        tick();

        // Version read: addr 0x37 -> 0xEE, slave returns 0x92
        resp[0] = 8'h5A; resp[1] = 8'h92;
        cf0 = mon_cs_falls;
        run_txn(1'b1, 6'h37, 6'd1, -1, -1);
        check("ver_mosi_n",   32'(mon_nbytes),  32'd2);
        check("ver_mosi0",    32'(mon_mosi[0]), 32'hEE);
        check("ver_mosi1",    32'(mon_mosi[1]), 32'h00);
        check("ver_rdv_n",    32'(n_rdv),       32'd1);
        check("ver_rd0",      32'(rd_log[0]),   32'h92);
        check("ver_err",      32'(t_err),       32'd0);
        check("ver_wrr_n",    32'(n_wrr),       32'd0);
        check("ver_cs_falls", 32'(mon_cs_falls - cf0), 32'd1);
        check("ver_setup",    32'(mon_t_rise1 - mon_t_cs_fall), 32'd100);
        check("ver_period",   32'(mon_t_rise2 - mon_t_rise1),   32'd50);
        check("ver_high",     32'(mon_t_fall1 - mon_t_rise1),   32'd25);
        check("ver_hold",     32'(mon_t_cs_rise - mon_t_last_fall), 32'd25);
        check("ver_gap",      32'(mon_t_done - mon_t_cs_rise),  32'd25);
        check("ver_busy_end", 32'(bus.busy),     32'd0);
        check("ver_cs_end",   32'(bus.spi_cs_n), 32'd1);
        check("ver_done_end", 32'(bus.done),     32'd0);

        // Single write: addr 0x01 -> 0x02, data 0x0F
        wr_arr[0] = 8'h0F;
        run_txn(1'b0, 6'h01, 6'd1, -1, -1);
        check("wr_mosi_n", 32'(mon_nbytes),  32'd2);
        check("wr_mosi0",  32'(mon_mosi[0]), 32'h02);
        check("wr_mosi1",  32'(mon_mosi[1]), 32'h0F);
        check("wr_wrr_n",  32'(n_wrr),       32'd1);
        check("wr_rdv_n",  32'(n_rdv),       32'd0);
        check("wr_err",    32'(t_err),       32'd0);
        check("wr_bits",   32'(mon_nrise),   32'd16);

        // Burst read addr 0x09 -> 0x92 x3 then 0x00, with a stray start mid-way
        resp[0] = 8'h33; resp[1] = 8'hA1; resp[2] = 8'hB2; resp[3] = 8'hC3;
        cf0 = mon_cs_falls;
        run_txn(1'b1, 6'h09, 6'd3, -1, 600);
        check("bst_mosi_n", 32'(mon_nbytes),  32'd4);
        check("bst_mosi0",  32'(mon_mosi[0]), 32'h92);
        check("bst_mosi1",  32'(mon_mosi[1]), 32'h92);
        check("bst_mosi2",  32'(mon_mosi[2]), 32'h92);
        check("bst_mosi3",  32'(mon_mosi[3]), 32'h00);
        check("bst_rdv_n",  32'(n_rdv),       32'd3);
        check("bst_rd0",    32'(rd_log[0]),   32'hA1);
        check("bst_rd1",    32'(rd_log[1]),   32'hB2);
        check("bst_rd2",    32'(rd_log[2]),   32'hC3);
        check("bst_done_n", 32'(n_done),      32'd1);
        check("bst_cs_falls", 32'(mon_cs_falls - cf0), 32'd1);
        repeat (20) tick();
        check("bst_no_restart", 32'(mon_cs_falls - cf0), 32'd1);

        // Write len=2 (addr 0x11 -> 0x22) with second byte withheld 500 cycles
        wr_arr[0] = 8'h3C; wr_arr[1] = 8'hC5;
        run_txn(1'b0, 6'h11, 6'd2, 1, -1);
        check("stl_mosi_n", 32'(mon_nbytes),  32'd3);
        check("stl_mosi0",  32'(mon_mosi[0]), 32'h22);
        check("stl_mosi1",  32'(mon_mosi[1]), 32'h3C);
        check("stl_mosi2",  32'(mon_mosi[2]), 32'hC5);
        check("stl_bits",   32'(mon_nrise),   32'd24);
        check("stl_wrr_n",  32'(n_wrr),       32'd2);
        check("stl_bad",    32'(stall_bad),   32'd0);
        check("stl_seen",   32'(stall_cyc >= 50), 32'd1);

        // Reset mid-bit in byte 1 of a read
        resp[0] = 8'h5A; resp[1] = 8'h92; resp[2] = 8'h44;
        bus.rw = 1'b1; bus.addr = 6'h37; bus.len = 6'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            tick();
            if (mon_nrise >= 12) found = 1'b1;
        end
        check("rst_reach", 32'(found), 32'd1);
        repeat (3) tick();
        check("pre_rst_sclk", 32'(bus.spi_sclk), 32'd1);
        check("pre_rst_cs_n", 32'(bus.spi_cs_n), 32'd0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_cs_n",    32'(bus.spi_cs_n), 32'd1);
        check("mid_rst_sclk",    32'(bus.spi_sclk), 32'd0);
        check("mid_rst_mosi",    32'(bus.spi_mosi), 32'd0);
        check("mid_rst_busy",    32'(bus.busy),     32'd0);
        check("mid_rst_rd_data", 32'(bus.rd_data),  32'h00);
        check("mid_rst_done",    32'(bus.done),     32'd0);
        tick();
        rst_n = 1'b1;
        extra_done = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (bus.done === 1'b1) extra_done++;
        end
        check("mid_rst_no_done", 32'(extra_done), 32'd0);

        // Normal operation after the aborted transaction
        run_txn(1'b1, 6'h37, 6'd1, -1, -1);
        check("post_mosi0", 32'(mon_mosi[0]), 32'hEE);
        check("post_mosi1", 32'(mon_mosi[1]), 32'h00);
        check("post_rdv_n", 32'(n_rdv),       32'd1);
        check("post_rd0",   32'(rd_log[0]),   32'h92);
        check("post_err",   32'(t_err),       32'd0);

        // len=0 is rejected on the next cycle with no SPI activity
        cf0 = mon_cs_falls;
        bus.rw = 1'b1; bus.addr = 6'h37; bus.len = 6'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        check("len0_done", 32'(bus.done),     32'd1);
        check("len0_err",  32'(bus.err),      32'd1);
        check("len0_busy", 32'(bus.busy),     32'd0);
        check("len0_cs_n", 32'(bus.spi_cs_n), 32'd1);
        extra_done = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (bus.done === 1'b1) extra_done++;
        end
        check("len0_single_done", 32'(extra_done), 32'd0);
        check("len0_no_cs", 32'(mon_cs_falls - cf0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mfrc522_spi_master.md
MFRC522_SPI_MASTER -- requirements
Module: mfrc522_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 25, meaning system cycles per SCLK half-period; legal values are 2 or more.
REQ-002 Parameter CS_SETUP, default 100, meaning cycles between CS falling and the first SCLK rising edge.
REQ-003 Parameter CS_HOLD, default 25, meaning cycles between the last SCLK falling edge and CS rising; CS then stays high for the same count before done.
REQ-004 Parameter LEN_W, default 6, meaning width of the length field; maximum burst is 2^LEN_W-1 data bytes.
REQ-005 clk_25mhz  in  1  system clock; the only clock.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  request strobe, sampled in IDLE only.
REQ-008 rw  in  1  1 = register read, 0 = register write; captured with start.
REQ-009 addr  in  6  MFRC522 register address; captured with start.
REQ-010 len  in  LEN_W  data byte count; captured with start.
REQ-011 wr_data  in  8  write data byte.
REQ-012 wr_valid  in  1  wr_data valid.
REQ-013 wr_ready  out  1  one-cycle pulse; the byte on wr_data is consumed in that cycle.
REQ-014 rd_data  out  8  received byte; held until the next rd_valid.
REQ-015 rd_valid  out  1  one-cycle pulse per received read byte.
REQ-016 busy  out  1  transaction in progress.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 err  out  1  qualifies done; set for a rejected request.
REQ-019 spi_sclk  out  1  SPI clock, mode 0, idle low.
REQ-020 spi_cs_n  out  1  chip select, active-low.
REQ-021 spi_mosi  out  1  serial data out, MSB first.
REQ-022 spi_miso  in  1  serial data in.

Function
REQ-023 States: IDLE, SETUP, LOAD, SHIFT, HOLD, GAP, DONE.
REQ-024 In IDLE with start=1 and len!=0: capture rw/addr/len, go to SETUP; spi_cs_n=0 and busy=1 from the next cycle.
REQ-025 In IDLE with start=1 and len==0: no SPI activity; done=1 and err=1 on the next cycle.
REQ-026 start while busy is ignored; captured fields do not change mid-transaction.
REQ-027 Address byte is {rw, addr, 1'b0}.
REQ-028 Wire bytes: len+1 in total. Read sends the address byte len times, then 0x00. Write sends the address byte, then len bytes from wr_data.
REQ-029 Read: the byte received during wire byte k (k=1..len) is presented on rd_data with rd_valid the cycle after its 8th rising edge; the byte received during byte 0 is discarded.
REQ-030 Bit timing: MOSI is valid CLK_DIV cycles before each rising edge; SCLK stays high CLK_DIV cycles, then low CLK_DIV cycles; MISO is sampled on the cycle SCLK rises.
REQ-031 Write LOAD: wr_ready pulses in the cycle wr_valid=1 is seen. If wr_valid=0, stay in LOAD with SCLK low and CS low indefinitely (underrun stall), with no extra SCLK edges.
REQ-032 After the final bit: HOLD for CS_HOLD cycles with SCLK low, then spi_cs_n=1. GAP lasts CS_HOLD cycles. DONE pulses done=1, err=0, and returns to IDLE with busy=0.
REQ-033 Internal counters are sized for the parameters; the byte counter does not wrap at len=2^LEN_W-1.
REQ-034 spi_sclk and spi_cs_n are driven from registers, glitch-free.

Reset
REQ-035 rst_n=0 at any clock edge, including mid-byte, sets the state to IDLE and these outputs on that edge: spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, err=0, wr_ready=0, rd_valid=0, rd_data=0x00. A partial transaction produces no done.

Verification
REQ-036 Version read (rw=1, addr=0x37, len=1), MISO model returns 0x92 -> MOSI 0xEE,0x00; one rd_valid with rd_data=0x92; done with err=0. With CLK_DIV=25 the SCLK period is 50 cycles (500 kHz) and the CS_SETUP gap is 100 cycles.
REQ-037 Write (rw=0, addr=0x01, len=1, wr_data=0x0F) -> MOSI 0x02,0x0F; exactly one wr_ready; no rd_valid.
REQ-038 Burst read (addr=0x09, len=3), model returns 0xA1,0xB2,0xC3 -> MOSI 0x92,0x92,0x92,0x00; rd_data sequence 0xA1,0xB2,0xC3.
REQ-039 Write len=2 with second wr_valid withheld 500 cycles -> SCLK low and CS low throughout the stall; the second byte is correct and the bit count is exactly 24.
REQ-040 rst_n pulsed low mid-bit in byte 1 -> CS high and SCLK low on that edge; no done; the next start works normally.
REQ-041 len=0 -> done=1 and err=1 one cycle after start; CS never asserts. start pulsed during busy -> ignored.
